// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: pixel-rate divider, h/v counters, framebuffer address
// presentation and a registered RGB/sync/blank output stage one pixel behind the address.
`timescale 1ns/1ps

module vga_scanout #(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        rd_en,
    input  logic [11:0] vga_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start,
    output logic        vblank
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_n_q, blank_n_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_q, vblank_d;

    logic pix_tick_c;
    logic h_wrap_c;
    logic v_wrap_c;
    logic active_c;
    logic hsync_c;
    logic vsync_c;

    // Region decode from the pre-increment counters
    always_comb begin
        pix_tick_c = (div_q == DIV_W'(PIX_DIV - 1));
        h_wrap_c   = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap_c   = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        active_c   = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        hsync_c    = (h_cnt_q >= CNT_W'(HS_BEG)) && (h_cnt_q < CNT_W'(HS_END));
        vsync_c    = (v_cnt_q >= CNT_W'(VS_BEG)) && (v_cnt_q < CNT_W'(VS_END));
    end

    // Next state: everything except the divider moves only on pix_tick
    always_comb begin
        div_d         = div_q + DIV_W'(1);
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_n_d     = blank_n_q;
        vblank_d      = vblank_q;
        frame_start_d = 1'b0;

        if (pix_tick_c) begin
            div_d   = '0;
            h_cnt_d = h_wrap_c ? '0 : h_cnt_q + CNT_W'(1);
            if (h_wrap_c) begin
                v_cnt_d = v_wrap_c ? '0 : v_cnt_q + CNT_W'(1);
            end
            hs_d          = ~hsync_c;
            vs_d          = ~vsync_c;
            blank_n_d     = active_c;
            // Blanking is enforced here so stray framebuffer data never reaches the pins
            rgb_d         = active_c ? vga_data : 12'h000;
            vblank_d      = (v_cnt_d >= CNT_W'(V_ACTIVE));
            frame_start_d = h_wrap_c && v_wrap_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
        end
    end

    assign h_addr      = h_cnt_q;
    assign v_addr      = v_cnt_q;
    assign rd_en       = active_c;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-timing PIX_DIV=2 instance and a shrunken-timing PIX_DIV=3
// instance, both checked every cycle against a pixel-index arithmetic model.
`timescale 1ns/1ps

module tb_vga_scanout;

    localparam int unsigned B_PD = 3;
    localparam int unsigned B_HA = 16, B_HF = 2, B_HS = 4, B_HB = 3;
    localparam int unsigned B_VA = 8,  B_VF = 2, B_VS = 2, B_VB = 3;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        rd_en;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        fs;
        logic        vblank;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [9:0]  h_addr_a, v_addr_a, h_addr_b, v_addr_b;
    logic        rd_en_a, rd_en_b;
    logic [11:0] data_a, data_b, data_b1;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, blank_a, fs_a, vblank_a;
    logic        hs_b, vs_b, blank_b, fs_b, vblank_b;

    logic        fff_mode = 1'b0;
    logic [11:0] key = 12'h000;

    int          checks = 0;
    int          failures = 0;
    int unsigned k = 0;

    int          last_fall = -1;
    bit          fall_seen = 1'b0;
    logic        prev_hs_a = 1'b1;
    bit          fb_started = 1'b0;
    int          fb_cyc, fb_blank, fb_vs_low, fb_vblank;

    vga_scanout u_dut_a (
        .clock(clock), .reset(reset), .h_addr(h_addr_a), .v_addr(v_addr_a), .rd_en(rd_en_a),
        .vga_data(data_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .vga_blank_n(blank_a), .frame_start(fs_a), .vblank(vblank_a)
    );

    vga_scanout #(
        .PIX_DIV(B_PD), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
    ) u_dut_b (
        .clock(clock), .reset(reset), .h_addr(h_addr_b), .v_addr(v_addr_b), .rd_en(rd_en_b),
        .vga_data(data_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .vga_blank_n(blank_b), .frame_start(fs_b), .vblank(vblank_b)
    );

    // Framebuffer stand-ins: 1-cycle latency for A, 2-cycle latency for B
    always @(posedge clock) begin
        data_a  <= fff_mode ? 12'hFFF : ({h_addr_a[3:0], v_addr_a[3:0], 4'h5} ^ key);
        data_b1 <= fff_mode ? 12'hFFF : ({h_addr_b[3:0], v_addr_b[3:0], 4'h5} ^ key);
        data_b  <= data_b1;
    end

    // Expected pins after the k-th clock edge since reset release
    function automatic exp_t model(int unsigned kk, int unsigned pd,
                                   int unsigned ha, int unsigned hf, int unsigned hsw, int unsigned hb,
                                   int unsigned va, int unsigned vf, int unsigned vsw, int unsigned vb,
                                   logic fff, logic [11:0] kx);
        exp_t e;
        int unsigned ht, vt, n, h, v, m, hm, vm;
        logic act;
        logic [11:0] pix;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        n  = kk / pd;
        h  = n % ht;
        v  = (n / ht) % vt;
        e.h      = 10'(h);
        e.v      = 10'(v);
        e.rd_en  = (h < ha) && (v < va);
        e.vblank = (v >= va);
        e.fs     = (n > 0) && (kk % pd == 0) && (n % (ht * vt) == 0);
        if (n == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0; e.rgb = 12'h000;
        end else begin
            m   = n - 1;
            hm  = m % ht;
            vm  = (m / ht) % vt;
            act = (hm < ha) && (vm < va);
            pix = fff ? 12'hFFF : ({4'(hm), 4'(vm), 4'h5} ^ kx);
            e.hs      = !((hm >= ha + hf) && (hm < ha + hf + hsw));
            e.vs      = !((vm >= va + vf) && (vm < va + vf + vsw));
            e.blank_n = act;
            e.rgb     = act ? pix : 12'h000;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            if (failures <= 30)
                $error("FAIL %s: observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic cycle();
        exp_t ea, eb;
        @(posedge clock);
        k = reset ? 0 : k + 1;
        @(negedge clock);
        ea = model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, fff_mode, key);
        eb = model(k, B_PD, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, fff_mode, key);

        chk("a_h_addr", 32'(h_addr_a), 32'(ea.h));
        chk("a_v_addr", 32'(v_addr_a), 32'(ea.v));
        chk("a_rd_en",  32'(rd_en_a),  32'(ea.rd_en));
        chk("a_rgb",    32'({r_a, g_a, b_a}), 32'(ea.rgb));
        chk("a_hs",     32'(hs_a),     32'(ea.hs));
        chk("a_vs",     32'(vs_a),     32'(ea.vs));
        chk("a_blank_n",32'(blank_a),  32'(ea.blank_n));
        chk("a_fs",     32'(fs_a),     32'(ea.fs));
        chk("a_vblank", 32'(vblank_a), 32'(ea.vblank));

        chk("b_h_addr", 32'(h_addr_b), 32'(eb.h));
        chk("b_v_addr", 32'(v_addr_b), 32'(eb.v));
        chk("b_rd_en",  32'(rd_en_b),  32'(eb.rd_en));
        chk("b_rgb",    32'({r_b, g_b, b_b}), 32'(eb.rgb));
        chk("b_hs",     32'(hs_b),     32'(eb.hs));
        chk("b_vs",     32'(vs_b),     32'(eb.vs));
        chk("b_blank_n",32'(blank_b),  32'(eb.blank_n));
        chk("b_fs",     32'(fs_b),     32'(eb.fs));
        chk("b_vblank", 32'(vblank_b), 32'(eb.vblank));

        if (reset) begin
            last_fall  = -1;
            fall_seen  = 1'b0;
            fb_started = 1'b0;
        end else begin
            // Measured hsync edges of the full-timing instance
            if (prev_hs_a && !hs_a) begin
                if (!fall_seen) chk("a_hs_first_fall", 32'(k), 32'(1314));
                else            chk("a_hs_period", 32'(int'(k) - last_fall), 32'(1600));
                fall_seen = 1'b1;
                last_fall = int'(k);
            end
            if (!prev_hs_a && hs_a && last_fall >= 0)
                chk("a_hs_width", 32'(int'(k) - last_fall), 32'(192));

            // Per-frame totals of the small instance, frame_start to frame_start
            if (fb_started) begin
                fb_cyc++;
                fb_blank  += int'(blank_b);
                fb_vs_low += int'(!vs_b);
                fb_vblank += int'(vblank_b);
            end
            if (fs_b) begin
                if (fb_started) begin
                    chk("b_frame_period", 32'(fb_cyc),    32'(25 * 15 * 3));
                    chk("b_blank_cycles", 32'(fb_blank),  32'(16 * 8 * 3));
                    chk("b_vs_low",       32'(fb_vs_low), 32'(2 * 25 * 3));
                    chk("b_vblank_cyc",   32'(fb_vblank), 32'(7 * 25 * 3));
                end
                fb_started = 1'b1;
                fb_cyc = 0; fb_blank = 0; fb_vs_low = 0; fb_vblank = 0;
            end
        end
        prev_hs_a = hs_a;
    endtask

    initial begin
        key = 12'($urandom);
        reset = 1'b1;
        repeat (5) cycle();
        reset = 1'b0;
        repeat (4000) cycle();

        // Mid-scan reset, then saturate the framebuffer to exercise forced blanking
        repeat ($urandom_range(37, 900)) cycle();
        reset = 1'b1;
        fff_mode = 1'b1;
        repeat (5) cycle();
        reset = 1'b0;
        repeat (3500) cycle();

        // Another random reset point with a fresh data pattern
        repeat ($urandom_range(1, 1600)) cycle();
        reset = 1'b1;
        fff_mode = 1'b0;
        key = 12'($urandom);
        repeat (5) cycle();
        reset = 1'b0;
        repeat (3500) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read-side counterpart of the VGA framebuffer: generates 640x480@60 timing, presents the current pixel's `h_addr`/`v_addr` to the framebuffer read port, and captures the returned 12-bit pixel. It outputs registered RGB444, sync and blanking to the VGA pins. It runs entirely in the single `clock` domain and derives the pixel rate with an internal clock-enable divider.

## Interface
- `PIX_DIV`, 2: `clock` cycles per pixel; legal range is 2..8.
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal timing, in pixels.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical timing, in lines.
- `clock`  in  1  system clock; one clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `h_addr`  out  10  column of the pixel currently being fetched; equals `h_cnt`.
- `v_addr`  out  10  row of the pixel currently being fetched; equals `v_cnt`.
- `rd_en`  out  1  high while (`h_cnt`,`v_cnt`) is inside the active area.
- `vga_data`  in  12  framebuffer read data for the address presented; bits {R[11:8], G[7:4], B[3:0]}.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  registered pixel colour.
- `vga_hs`, `vga_vs`  out  1 each  syncs, active-low.
- `vga_blank_n`  out  1  high while the output pixel is active.
- `frame_start`  out  1  one-cycle pulse when the counters wrap to (0,0).
- `vblank`  out  1  registered; high while `v_cnt >= V_ACTIVE`; intended for CPU polling.

## Operation
- Divider `div` counts 0..PIX_DIV-1 and wraps. `pix_tick = (div == PIX_DIV-1)`.
- Counters advance only on `pix_tick`:
  - `h_cnt` counts 0..H_TOTAL-1, with H_TOTAL = sum of H params (800).
  - On the `h_cnt` wrap, `v_cnt` counts 0..V_TOTAL-1, with V_TOTAL = 525. `v_cnt` wraps to 0 together with `h_cnt`.
- Regions:
  - Active: `h_cnt < H_ACTIVE` and `v_cnt < V_ACTIVE`.
  - hsync low when `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC` (656..751).
  - vsync low when `V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC` (490..491).
- Address path: `h_addr`/`v_addr` are driven straight from the counter registers, not gated by the active region. They are stable for exactly PIX_DIV cycles per pixel.
- Output stage, loaded on `pix_tick` from the current (pre-increment) counter values:
  - `vga_hs`, `vga_vs` take the sync decode.
  - `vga_blank_n` takes the active flag.
  - `{vga_r,vga_g,vga_b}` take `vga_data` if active, else 12'h000.
- Blanking is forced in the output stage: non-zero `vga_data` outside the active area never reaches the pins.
- `frame_start` is asserted for the single cycle following the `pix_tick` on which (799,524) wraps to (0,0).
- `vblank` is updated on every `pix_tick` from the new `v_cnt`.
- Reset values:
  - `div`, `h_cnt`, `v_cnt` = 0.
  - `vga_hs` = `vga_vs` = 1.
  - `vga_blank_n` = 0, RGB = 0, `frame_start` = 0, `vblank` = 0.
- Reset mid-frame: all state returns to the values above on the next edge. Scan restarts at pixel (0,0), with the first `pix_tick` PIX_DIV cycles after reset deasserts.

## Timing
- Framebuffer read latency must be at most PIX_DIV-1 cycles. `vga_data` is sampled on the last cycle of each address window. A 1-cycle synchronous BRAM is compatible with PIX_DIV=2.
- Output pixel latency is exactly one pixel period: pins show pixel (h,v) while `h_addr`/`v_addr` present (h+1,v). Sync and blank are delayed identically, so they stay aligned with the data.
- Line period = 800·PIX_DIV cycles. Frame period = 420000·PIX_DIV cycles.
- hsync low width = 96 pixels; vsync low width = 2 lines (1600 pixels).
- `rd_en` is combinational from the counters and changes only on cycles after `pix_tick`.
- Only `pix_tick` changes state: the design has no inputs other than `vga_data` and `reset`, so there are no simultaneous events to resolve.

## Test plan
- Reset: hold `reset` for 5 cycles at a random point in the scan -> all outputs take their reset values. The first `pix_tick` comes 2 cycles after release, `h_addr`=1 after it, `frame_start`=0 until wrap.
- Line and sync timing, PIX_DIV=2:
  - `vga_hs` falls 657·2 cycles after reset release and stays low for 192 cycles.
  - Successive falling edges of `vga_hs` are 1600 cycles apart.
- Frame timing: `vga_vs` low for exactly 2 lines (3200 cycles) per frame; `frame_start` pulses every 840000 cycles; `vblank` is high for 45 lines.
- Pixel path: the bench model returns `{h_addr[3:0], v_addr[3:0], 4'h5}` with 1-cycle latency.
  - Pins show RGB = {h[3:0], v[3:0], 5} for every active pixel, one pixel after the address.
  - `vga_blank_n` = 1 for exactly 640×480 pixels per frame.
- Blanking: drive `vga_data` = 12'hFFF constantly -> RGB = 0 whenever `vga_blank_n` = 0, including pixel 640 of each line and all of lines 480..524.
- Divider variant: with PIX_DIV=3 -> the address holds for 3 cycles, line period is 2400 cycles, and data sampled 2 cycles after the address change is displayed correctly.
